// File: rtl/gpu_pkg.sv
// Shared encodings for the tiny GPU core: scheduler, fetcher and LSU states plus block error codes.
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    REQUEST   = 3'd3,
    WAIT      = 3'd4,
    EXECUTE   = 3'd5,
    WRITEBACK = 3'd6,
    DONE      = 3'd7
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'd0,
    FETCHER_FETCHING = 3'd1,
    FETCHER_FETCHED  = 3'd2
  } fetcher_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIVERGE = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // An LSU still owns the warp while its request is outstanding.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/warp_pc_select.sv
// Picks the warp reference PC (lowest-indexed active thread) and flags any active thread
// whose next PC disagrees with it.
module warp_pc_select #(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 8
) (
  input  logic [NUM_THREADS-1:0]      active_mask,
  input  logic [PC_W*NUM_THREADS-1:0] next_pc,
  output logic [PC_W-1:0]             ref_pc,
  output logic                        diverged
);

  logic found;

  always_comb begin
    ref_pc = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (active_mask[i] && !found) begin
        ref_pc = next_pc[PC_W*i +: PC_W];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    diverged = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (active_mask[i] && (next_pc[PC_W*i +: PC_W] != ref_pc)) diverged = 1'b1;
    end
  end

endmodule

// File: rtl/core_scheduler_mt.sv
// Per-core warp scheduler: sequences lock-step threads through the instruction pipeline,
// with active mask, divergence abort, stall timeout, start/done handshake and cycle counter.
module core_scheduler_mt
  import gpu_pkg::*;
#(
  parameter int NUM_THREADS   = 4,
  parameter int PC_W          = 8,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [NUM_THREADS-1:0]      thread_mask,
  input  logic [2:0]                  fetcher_state,
  input  logic [2*NUM_THREADS-1:0]    lsu_state,
  input  logic                        program_end,
  input  logic [PC_W*NUM_THREADS-1:0] next_pc,
  output logic [PC_W-1:0]             current_pc,
  output logic [2:0]                  core_state,
  output logic [NUM_THREADS-1:0]      active_mask,
  output logic                        done,
  output logic [1:0]                  error_code,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int  ST_W    = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam int  TO_LAST = (STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1;
  localparam bit  TO_EN   = (STALL_TIMEOUT != 0);
  localparam logic [ST_W-1:0] TO_LAST_V = ST_W'(TO_LAST);

  core_state_t            state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d;
  logic [1:0]             err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ST_W-1:0]        stall_q, stall_d;

  logic [PC_W-1:0] ref_pc;
  logic            diverged;
  logic            lsu_stall;
  logic            fetched;
  logic            timeout_hit;

  warp_pc_select #(
    .NUM_THREADS (NUM_THREADS),
    .PC_W        (PC_W)
  ) u_pc_select (
    .active_mask (mask_q),
    .next_pc     (next_pc),
    .ref_pc      (ref_pc),
    .diverged    (diverged)
  );

  // Only threads in the latched mask can hold the warp in WAIT.
  always_comb begin
    lsu_stall = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (mask_q[i] && lsu_busy(lsu_state[2*i +: 2])) lsu_stall = 1'b1;
    end
  end

  assign fetched     = (fetcher_state == FETCHER_FETCHED);
  assign timeout_hit = TO_EN && (stall_q == TO_LAST_V);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    stall_d = '0;

    if ((state_q != IDLE) && (state_q != DONE) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = thread_mask;
          cnt_d   = '0;
          err_d   = ERR_NONE;
          pc_d    = '0;
          state_d = (thread_mask != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (fetched) begin
          state_d = DECODE;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = ERR_TIMEOUT;
        end
      end
      DECODE:  state_d = REQUEST;
      REQUEST: state_d = WAIT;
      WAIT: begin
        if (!lsu_stall) begin
          state_d = EXECUTE;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = ERR_TIMEOUT;
        end
      end
      EXECUTE: state_d = WRITEBACK;
      WRITEBACK: begin
        if (program_end) begin
          state_d = DONE;
        end else if (diverged) begin
          state_d = DONE;
          err_d   = ERR_DIVERGE;
        end else begin
          pc_d    = ref_pc;
          state_d = FETCH;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The timer restarts on every state entry, so it only runs while a stall persists.
    if (TO_EN && (state_d == state_q) && ((state_q == FETCH) || (state_q == WAIT)))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign current_pc  = pc_q;
  assign core_state  = state_q;
  assign active_mask = mask_q;
  assign done        = (state_q == DONE);
  assign error_code  = err_q;
  assign cycle_count = cnt_q;

endmodule
